// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Read-side controller for an upstream synchronous FIFO with a
//               one-cycle read latency. Issues read requests, captures the
//               returned words into a 3-entry in-order skid buffer and presents
//               them as a valid/ready output stream. The read request never
//               depends on m_ready, so the FIFO interface has no combinational
//               path from the downstream consumer.
//
// Ports       : clk         - clock, all state updates on the rising edge
//               rst         - synchronous reset, active low
//               en          - read enable, gates issuing of new FIFO reads
//               fifo_empty  - upstream FIFO empty flag
//               fifo_data   - upstream FIFO read data (one cycle after read)
//               fifo_rd_en  - read request to the upstream FIFO
//               m_valid     - output stream valid
//               m_ready     - output stream ready (downstream accepts)
//               m_data      - output stream data (buffer head)
//               beat_cnt    - 16-bit accepted-beat counter, wraps at 0xFFFF
//                             (only when FIFO_RD_CNT_EN is defined)
//
// Options     : FIFO_RD_CNT_EN - define to add the beat_cnt port and counter
//
// Revision    : 1.0 - initial release
// ============================================================================

module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]           beat_cnt
`endif
);

  // Buffer geometry: three entries addressed by 2-bit indices that wrap 2 -> 0.
  localparam logic [1:0] C_LAST_IDX = 2'd2;
  localparam logic [2:0] C_DEPTH    = 3'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_buf [0:2];
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [1:0]            r_count;
  logic                  r_inflight;

  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occupancy;
  logic                  w_has_room;

  function automatic logic [1:0] f_next_idx(input logic [1:0] idx);
    return (idx == C_LAST_IDX) ? 2'd0 : idx + 2'd1;
  endfunction

  // --------------------------------------------------------------------------
  // Read request
  // --------------------------------------------------------------------------
  // A word already in flight still needs a slot, so it is counted against the
  // buffer capacity before another read is issued. This guarantees the
  // returned word always has room and lets us ignore m_ready here.
  always_comb begin
    w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    w_has_room  = (w_occupancy < C_DEPTH);
  end

  // Gated with rst so no read is requested while reset is held; otherwise a
  // word would be pulled from the FIFO and silently dropped.
  assign fifo_rd_en = rst && en && !fifo_empty && w_has_room;

  // --------------------------------------------------------------------------
  // Output stream
  // --------------------------------------------------------------------------
  assign m_valid = rst && (r_count != 2'd0);
  assign m_data  = r_buf[r_head];

  // The in-flight word lands on the buffer tail on the edge after the read.
  assign w_push = r_inflight;
  assign w_pop  = m_valid && m_ready;

  // --------------------------------------------------------------------------
  // Buffer, pointers, occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_buf[2]   <= '0;
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;

      if (w_push) begin
        r_buf[r_tail] <= fifo_data;
        r_tail        <= f_next_idx(r_tail);
      end

      if (w_pop) begin
        r_head <= f_next_idx(r_head);
      end

      // Capture and pop on the same edge leave the count unchanged; head and
      // tail both advance so ordering is preserved.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  // --------------------------------------------------------------------------
  // Accepted-beat counter (wraps naturally at 16 bits)
  // --------------------------------------------------------------------------
  logic [15:0] r_beat_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_beat_cnt <= 16'h0000;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + 16'h0001;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

`default_nettype wire
